// File: rtl/xdma_w_beat_framer.sv
// Frames the converted beat stream into AXI4 W-channel bursts: registered W output,
// per-burst w_last generation, and a one-cycle done pulse at end of transfer.
module xdma_w_beat_framer #(
    parameter int unsigned DW    = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CNT_W-1:0] cfg_num_beats_i,
    input  logic [7:0]       cfg_len_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [DW-1:0]    data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [DW-1:0]    w_data_o,
    output logic [DW/8-1:0]  w_strb_o,
    output logic             w_last_o,
    output logic             w_valid_o,
    input  logic             w_ready_i,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_in_q, rem_out_q;
    logic [7:0]       len_q, burst_cnt_q;
    logic             cfg_hs, in_hs, w_hs, beat_last;

    assign cfg_hs    = cfg_valid_i && cfg_ready_o;
    assign w_hs      = w_valid_o && w_ready_i;
    // Accept a new beat only if the output register is empty or draining this cycle.
    assign ready_o   = (state_q == StStream) && (rem_in_q != '0) && (!w_valid_o || w_ready_i);
    assign in_hs     = valid_i && ready_o;
    assign beat_last = (burst_cnt_q == len_q) || (rem_in_q == CNT_W'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_hs) begin
                    state_d = (cfg_num_beats_i == '0) ? StDone : StStream;
                end
            end
            StStream: begin
                if (w_hs && (rem_out_q == CNT_W'(1))) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cfg_ready_o = (state_q == StIdle);
        busy_o      = (state_q != StIdle);
        done_o      = (state_q == StDone);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_q       <= '0;
            rem_in_q    <= '0;
            rem_out_q   <= '0;
            burst_cnt_q <= '0;
        end else if (cfg_hs) begin
            len_q       <= cfg_len_i;
            rem_in_q    <= cfg_num_beats_i;
            rem_out_q   <= cfg_num_beats_i;
            burst_cnt_q <= '0;
        end else begin
            if (in_hs) begin
                rem_in_q    <= rem_in_q - CNT_W'(1);
                burst_cnt_q <= beat_last ? 8'd0 : burst_cnt_q + 8'd1;
            end
            if (w_hs) begin
                rem_out_q <= rem_out_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_data_o  <= '0;
            w_strb_o  <= '0;
            w_last_o  <= 1'b0;
            w_valid_o <= 1'b0;
        end else if (in_hs) begin
            w_data_o  <= data_i;
            w_strb_o  <= '1;
            w_last_o  <= beat_last;
            w_valid_o <= 1'b1;
        end else if (w_ready_i) begin
            w_valid_o <= 1'b0;
        end
    end

endmodule
